// File: rtl/scan_pkg.sv
// Shared types and the hex-to-segment decode for the display scan controller.
// Segment codes are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scan_state_t;

    localparam logic [6:0] SEG_OFF_AH = 7'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h71;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell divider: pulses tick_o while the count sits at DIV_COUNT,
// then wraps to zero; clear_i holds the count at zero.
module scan_tick_gen #(
    parameter int DIV_COUNT = 27000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int W = (DIV_COUNT > 0) ? $clog2(DIV_COUNT + 1) : 1;
    localparam logic [W-1:0] TERM = W'(DIV_COUNT);

    logic [W-1:0] r_cnt;
    logic         w_term;

    assign w_term = (r_cnt == TERM);
    assign tick_o = w_term && !clear_i;

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with an
// inter-digit blanking gap; all outputs are registered.
module display_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV_COUNT    = 27000,
    parameter int BLANK_CYCLES = 16,
    parameter int NUM_DIGITS   = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic [2:0]              idx_o,
    output logic                    frame_done_o
);

    localparam int GW = $clog2(BLANK_CYCLES + 1);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};
    localparam logic [6:0] SEG_OFF = POL ? ~SEG_OFF_AH : SEG_OFF_AH;
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(BLANK_CYCLES - 1);

    scan_state_t           r_state;
    logic [2:0]            r_idx;
    logic [GW-1:0]         r_gap;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_fd;

    logic                  w_tick;
    logic                  w_clear;
    logic                  w_last_idx;
    logic                  w_last_gap;
    logic [2:0]            w_next_idx;
    logic [2:0]            w_show_idx;
    logic [31:0]           w_dig_pad;
    logic [7:0]            w_blk_pad;
    logic [3:0]            w_nib;
    logic [7:0]            w_oh8;
    logic [NUM_DIGITS-1:0] w_an_new;
    logic [6:0]            w_seg_ah;
    logic [6:0]            w_seg_new;

    assign w_clear    = (r_state != SHOW);
    assign w_last_idx = (r_idx == LAST_IDX);
    assign w_last_gap = (r_gap == LAST_GAP);
    assign w_next_idx = w_last_idx ? 3'd0 : r_idx + 3'd1;
    // Digit about to be entered: from IDLE it is always digit 0.
    assign w_show_idx = (r_state == BLANK) ? w_next_idx : 3'd0;

    assign w_dig_pad = 32'(digits_i);
    assign w_blk_pad = 8'(blank_i);
    assign w_nib     = w_dig_pad[{w_show_idx, 2'b00} +: 4];
    assign w_oh8     = 8'd1 << w_show_idx;
    assign w_an_new  = POL ? ~w_oh8[NUM_DIGITS-1:0] : w_oh8[NUM_DIGITS-1:0];
    assign w_seg_ah  = w_blk_pad[w_show_idx] ? SEG_OFF_AH : hex_to_seg(w_nib);
    assign w_seg_new = POL ? ~w_seg_ah : w_seg_ah;

    scan_tick_gen #(
        .DIV_COUNT(DIV_COUNT)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear_i(w_clear),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_gap   <= '0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
            r_fd    <= 1'b0;
        end else begin
            r_fd <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_idx <= '0;
                    r_an  <= AN_OFF;
                    r_seg <= SEG_OFF;
                    if (en_i) begin
                        r_state <= SHOW;
                        r_an    <= w_an_new;
                        r_seg   <= w_seg_new;
                    end
                end
                SHOW: begin
                    if (!en_i) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        r_an    <= AN_OFF;
                        r_seg   <= SEG_OFF;
                    end else if (w_tick) begin
                        r_state <= BLANK;
                        r_gap   <= '0;
                        r_an    <= AN_OFF;
                        r_seg   <= SEG_OFF;
                    end
                end
                BLANK: begin
                    if (!en_i) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                    end else if (w_last_gap) begin
                        r_state <= SHOW;
                        r_idx   <= w_next_idx;
                        r_an    <= w_an_new;
                        r_seg   <= w_seg_new;
                        r_fd    <= w_last_idx;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_an    <= AN_OFF;
                    r_seg   <= SEG_OFF;
                end
            endcase
        end
    end

    assign an_o         = r_an;
    assign seg_o        = r_seg;
    assign idx_o        = r_idx;
    assign frame_done_o = r_fd;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: timeline model of the scan plus
// directed checks on literal segment/anode values.
module tb_display_scan_ctrl;

    localparam int DIV   = 3;
    localparam int BLK   = 2;
    localparam int ND    = 4;
    localparam int SLOT  = DIV + 1 + BLK;
    localparam int FRAME = ND * SLOT;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic [15:0] digits_i;
    logic [3:0]  blank_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic [2:0]  idx_o;
    logic        frame_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    display_scan_ctrl #(
        .DIV_COUNT   (DIV),
        .BLANK_CYCLES(BLK),
        .NUM_DIGITS  (ND),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .digits_i    (digits_i),
        .blank_i     (blank_i),
        .an_o        (an_o),
        .seg_o       (seg_o),
        .idx_o       (idx_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: position within the run since the last enable/reset decides everything.
    bit         m_valid = 0;
    bit         m_run   = 0;
    int         m_t     = 0;
    logic [3:0] m_nib;
    logic       m_blk;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [2:0] exp_idx;
    logic       exp_fd;

    always @(posedge clk) begin
        int pos;
        int slot;
        int off;
        logic [15:0] sh;
        if (!rst) begin
            m_valid = 1;
            m_run   = 0;
        end else if (!en_i) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_t   = 0;
        end else begin
            m_t++;
        end
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_idx = 3'd0;
        exp_fd  = 1'b0;
        if (m_run) begin
            pos  = m_t % FRAME;
            slot = pos / SLOT;
            off  = pos % SLOT;
            if (off == 0) begin
                sh    = digits_i >> (4 * slot);
                m_nib = sh[3:0];
                m_blk = blank_i[slot];
            end
            exp_idx = 3'(slot);
            exp_fd  = (m_t > 0) && (pos == 0);
            if (off <= DIV) begin
                exp_an  = ~(4'b0001 << slot);
                exp_seg = m_blk ? 7'h7F : ~HEX[m_nib];
            end
        end
    end

    int cyc = 0;
    bit rec = 0;
    int fd_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (m_valid) begin
            chk("an", 32'(an_o), 32'(exp_an));
            chk("seg", 32'(seg_o), 32'(exp_seg));
            chk("idx", 32'(idx_o), 32'(exp_idx));
            chk("frame_done", 32'(frame_done_o), 32'(exp_fd));
            chk("an_onehot", 32'($countones(~an_o) <= 1), 32'd1);
            if (frame_done_o === 1'b1) begin
                chk("fd_idx0", 32'(idx_o), 32'd0);
                chk("fd_an0", 32'(an_o), 32'hE);
                if (rec) fd_q.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        while (frame_done_o !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_fd_timeout", 32'(k < 100), 32'd1);
    endtask

    initial begin
        rst      = 1'b0;
        en_i     = 1'b0;
        digits_i = 16'h0;
        blank_i  = 4'h0;
        step(3);
        chk("rst_an", 32'(an_o), 32'hF);
        chk("rst_seg", 32'(seg_o), 32'h7F);
        chk("rst_idx", 32'(idx_o), 32'd0);
        chk("rst_fd", 32'(frame_done_o), 32'd0);

        // Test 1: first digits of 4321.
        rst      = 1'b1;
        en_i     = 1'b1;
        digits_i = 16'h4321;
        step(1);
        chk("t1_an0", 32'(an_o), 32'hE);
        chk("t1_seg0", 32'(seg_o), 32'h79);
        step(3);
        chk("t1_seg0_end", 32'(seg_o), 32'h79);
        step(1);
        chk("t1_blank_an", 32'(an_o), 32'hF);
        chk("t1_blank_seg", 32'(seg_o), 32'h7F);
        step(1);
        chk("t1_blank2_an", 32'(an_o), 32'hF);
        step(1);
        chk("t1_an1", 32'(an_o), 32'hD);
        chk("t1_seg1", 32'(seg_o), 32'h24);

        // Test 2: three frames, pulses 24 cycles apart.
        fd_q.delete();
        rec = 1;
        step(3 * FRAME);
        rec = 0;
        chk("t2_pulses", 32'(fd_q.size()), 32'd3);
        for (int i = 1; i < fd_q.size(); i++)
            chk("t2_period", 32'(fd_q[i] - fd_q[i-1]), 32'd24);

        // Test 3: blanked digit 2.
        digits_i = 16'h8888;
        blank_i  = 4'b0100;
        wait_fd();
        chk("t3_d0_seg", 32'(seg_o), 32'h00);
        step(SLOT);
        chk("t3_d1_an", 32'(an_o), 32'hD);
        chk("t3_d1_seg", 32'(seg_o), 32'h00);
        step(SLOT);
        chk("t3_d2_an", 32'(an_o), 32'hB);
        chk("t3_d2_seg", 32'(seg_o), 32'h7F);

        // Test 4: input change mid-dwell is not seen.
        digits_i = 16'h0000;
        blank_i  = 4'h0;
        wait_fd();
        chk("t4_seg_c1", 32'(seg_o), 32'h40);
        step(1);
        digits_i = 16'hFFFF;
        step(1);
        chk("t4_seg_c3", 32'(seg_o), 32'h40);
        step(1);
        chk("t4_seg_c4", 32'(seg_o), 32'h40);
        step(3);
        chk("t4_d1_seg", 32'(seg_o), 32'h0E);

        // Test 5: disable during BLANK of digit 2.
        wait_fd();
        step(2 * SLOT + DIV + 1);
        chk("t5_in_blank", 32'(an_o), 32'hF);
        en_i = 1'b0;
        step(1);
        chk("t5_off_an", 32'(an_o), 32'hF);
        chk("t5_off_idx", 32'(idx_o), 32'd0);
        chk("t5_off_fd", 32'(frame_done_o), 32'd0);
        en_i = 1'b1;
        step(1);
        chk("t5_restart_an", 32'(an_o), 32'hE);
        chk("t5_restart_fd", 32'(frame_done_o), 32'd0);

        // Test 6: reset pulse during SHOW of digit 3.
        step(3 * SLOT + 1);
        chk("t6_d3_an", 32'(an_o), 32'h7);
        rst = 1'b0;
        step(1);
        chk("t6_rst_an", 32'(an_o), 32'hF);
        chk("t6_rst_seg", 32'(seg_o), 32'h7F);
        chk("t6_rst_idx", 32'(idx_o), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < DIV + 1; i++) begin
            step(1);
            chk("t6_dwell", 32'(an_o), 32'hE);
        end
        step(1);
        chk("t6_dwell_end", 32'(an_o), 32'hF);

        // Randomised run checked by the model.
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if ($urandom_range(0, 9) == 0) digits_i = 16'($urandom);
            if ($urandom_range(0, 19) == 0) blank_i = 4'($urandom);
            en_i = ($urandom_range(0, 49) != 0);
            rst  = ($urandom_range(0, 99) != 0);
        end
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
